// File: rtl/alarm_snooze_ctrl.sv
// Alarm ringing-session controller: consumes the latched alarm level, clears the
// upstream latch with a one-cycle stop pulse, then runs ring / snooze / dismiss /
// timeout for the event on the 1 Hz tick.
module alarm_snooze_ctrl #(
    parameter int SNOOZE_SEC       = 300,
    parameter int RING_TIMEOUT_SEC = 60,
    parameter int MAX_SNOOZE       = 3
) (
    input  logic       clk_1s,
    input  logic       reset,
    input  logic       alarm_in,
    input  logic       snooze_btn,
    input  logic       dismiss_btn,
    output logic       stop_al,
    output logic       buzzer,
    output logic       ringing,
    output logic       snoozing,
    output logic [1:0] state,
    output logic [2:0] snooze_cnt,
    output logic [9:0] snooze_left,
    output logic       timed_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_t;

    localparam logic [9:0] SNOOZE_LEN   = 10'(SNOOZE_SEC);
    localparam logic [7:0] TIMEOUT_LAST = 8'(RING_TIMEOUT_SEC - 1);
    localparam logic [2:0] MAX_CNT      = 3'(MAX_SNOOZE);

    state_t     cur_state, nxt_state;
    logic [7:0] ring_timer, nxt_timer;
    logic [9:0] nxt_left;
    logic [2:0] nxt_cnt;
    logic       nxt_to;
    logic       nxt_stop;
    logic       armed, nxt_armed;

    // State and session registers; everything clears immediately on reset.
    always_ff @(posedge clk_1s or posedge reset) begin
        if (reset) begin
            cur_state   <= IDLE;
            ring_timer  <= '0;
            snooze_left <= '0;
            snooze_cnt  <= '0;
            timed_out   <= 1'b0;
            stop_al     <= 1'b0;
            armed       <= 1'b0;
        end else begin
            cur_state   <= nxt_state;
            ring_timer  <= nxt_timer;
            snooze_left <= nxt_left;
            snooze_cnt  <= nxt_cnt;
            timed_out   <= nxt_to;
            stop_al     <= nxt_stop;
            armed       <= nxt_armed;
        end
    end

    // Next-state and next-counter logic for the ringing session.
    always_comb begin
        nxt_state = cur_state;
        nxt_timer = ring_timer;
        nxt_left  = snooze_left;
        nxt_cnt   = snooze_cnt;
        nxt_to    = timed_out;
        nxt_stop  = 1'b0;
        // Re-arm only after the upstream level has been seen low, so the latch
        // (which clears one edge after stop_al) cannot retrigger the event.
        nxt_armed = armed | ~alarm_in;
        unique case (cur_state)
            IDLE: begin
                if (alarm_in && armed) begin
                    nxt_state = RING;
                    nxt_timer = '0;
                    nxt_cnt   = '0;
                    nxt_to    = 1'b0;
                    nxt_stop  = 1'b1;
                    nxt_armed = 1'b0;
                end
            end
            RING: begin
                nxt_timer = ring_timer + 8'd1;
                if (dismiss_btn) begin
                    nxt_state = IDLE;
                    nxt_left  = '0;
                end else if (snooze_btn && (snooze_cnt < MAX_CNT)) begin
                    nxt_state = SNOOZE;
                    nxt_left  = SNOOZE_LEN;
                    nxt_cnt   = snooze_cnt + 3'd1;
                end else if (ring_timer == TIMEOUT_LAST) begin
                    nxt_state = IDLE;
                    nxt_to    = 1'b1;
                    nxt_left  = '0;
                end
            end
            SNOOZE: begin
                nxt_left = snooze_left - 10'd1;
                if (dismiss_btn) begin
                    nxt_state = IDLE;
                    nxt_left  = '0;
                end else if (snooze_left == 10'd1) begin
                    nxt_state = RING;
                    nxt_timer = '0;
                    nxt_left  = '0;
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_left  = '0;
            end
        endcase
    end

    // Decoded outputs; buzzer beeps on even seconds of the ring session.
    always_comb begin
        state    = cur_state;
        ringing  = (cur_state == RING);
        snoozing = (cur_state == SNOOZE);
        buzzer   = (cur_state == RING) && !ring_timer[0];
    end

endmodule
